// File: rtl/oscilo_pkg.sv
// Shared types and widths for the oscilloscope capture path
// (trigger_sampler, sample_reader, sample RAM).
package oscilo_pkg;

  localparam int unsigned SAMPLE_WIDTH = 8;
  localparam int unsigned SAMPLE_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StArmed,
    StPost,
    StDone
  } cap_state_e;

  function automatic logic cap_running(cap_state_e st);
    return (st == StPrefill) || (st == StArmed) || (st == StPost);
  endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// ADC clock divider: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise,
// and emits a one-cycle strobe on the last count of each ADC period.
module adc_clk_gen #(
  parameter int unsigned CLK_DIV = 50
) (
  input  logic clk_50mhz,
  input  logic reset,
  input  logic enable,
  output logic adc_clk,
  output logic strobe
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated so the ADC clock rests low whenever the divider is parked.
  assign adc_clk = enable && (cnt_q < HALF);
  assign strobe  = enable && (cnt_q == LAST);

endmodule

// File: rtl/trigger_sampler.sv
// Triggered capture engine: ring-buffers ADC samples into the sample RAM and
// stops once PRETRIG samples precede the trigger, reporting the oldest address.
module trigger_sampler
  import oscilo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
  parameter int unsigned ADDR_WIDTH = SAMPLE_ADDR_WIDTH,
  parameter int unsigned PRETRIG    = 64,
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk_50mhz,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_rising,
  output logic                  adc_clk,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  forced
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam logic [ADDR_WIDTH-1:0] PRE      = ADDR_WIDTH'(PRETRIG);
  localparam logic [ADDR_WIDTH-1:0] POST_LEN = ADDR_WIDTH'(DEPTH - PRETRIG - 1);
  localparam logic [TW-1:0]         TO_LAST  = TW'(TIMEOUT - 1);

  cap_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] left_q, left_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] sample_q;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic rising_q, rising_d, prev_valid_q, prev_valid_d, forced_q, forced_d;
  logic wr_pend_q, running, strobe, wr, crossing, timeout_hit;

  assign running = cap_running(state_q);
  assign wr      = wr_pend_q && running;

  adc_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_adc_clk_gen (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .enable   (running),
    .adc_clk  (adc_clk),
    .strobe   (strobe)
  );

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      sample_q  <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      if (strobe) sample_q <= adc_data;
      wr_pend_q <= strobe;
    end
  end

  always_comb begin
    crossing = prev_valid_q &&
               (rising_q ? (prev_q < level_q && sample_q >= level_q)
                         : (prev_q > level_q && sample_q <= level_q));
    timeout_hit = (TIMEOUT != 0) && (tcnt_q == TO_LAST);
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    left_d       = left_q;
    trig_addr_d  = trig_addr_q;
    level_d      = level_q;
    rising_d     = rising_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    tcnt_d       = tcnt_q;
    forced_d     = forced_q;
    unique case (state_q)
      StIdle: begin
        if (activate) begin
          level_d      = trig_level;
          rising_d     = trig_rising;
          wptr_d       = '0;
          prev_valid_d = 1'b0;
          tcnt_d       = '0;
          left_d       = PRE;
          trig_addr_d  = '0;
          forced_d     = 1'b0;
          state_d      = (PRETRIG == 0) ? StArmed : StPrefill;
        end
      end
      StPrefill, StArmed, StPost: begin
        if (!activate) begin
          state_d     = StIdle;
          trig_addr_d = '0;
          forced_d    = 1'b0;
        end else if (wr) begin
          wptr_d       = wptr_q + ADDR_WIDTH'(1);
          prev_d       = sample_q;
          prev_valid_d = 1'b1;
          if (state_q == StArmed) begin
            tcnt_d = tcnt_q + TW'(1);
            // A crossing coinciding with the timeout is a real trigger.
            if (crossing || timeout_hit) begin
              trig_addr_d = wptr_q - PRE;
              forced_d    = !crossing;
              left_d      = POST_LEN;
              state_d     = (POST_LEN == '0) ? StDone : StPost;
            end
          end else begin
            left_d = left_q - ADDR_WIDTH'(1);
            if (left_q == ADDR_WIDTH'(1)) begin
              state_d = (state_q == StPrefill) ? StArmed : StDone;
            end
          end
        end
      end
      StDone: begin
        if (!activate) begin
          state_d     = StIdle;
          trig_addr_d = '0;
          forced_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      left_q       <= '0;
      trig_addr_q  <= '0;
      level_q      <= '0;
      rising_q     <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      tcnt_q       <= '0;
      forced_q     <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      left_q       <= left_d;
      trig_addr_q  <= trig_addr_d;
      level_q      <= level_d;
      rising_q     <= rising_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      tcnt_q       <= tcnt_d;
      forced_q     <= forced_d;
    end
  end

  always_comb begin
    mem_we    = wr;
    mem_addr  = wptr_q;
    mem_data  = sample_q;
    done      = (state_q == StDone);
    trig_addr = trig_addr_q;
    forced    = forced_q;
  end

endmodule
